rftfa_checker: RTL

RFTFA_CHECKER -- requirements
Module: rftfa_checker

---
 rtl/rftfa_checker.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/rftfa_checker.sv
// rftfa_checker: two-stage response checker for an RFTFA (reversible
// full-adder style 4-bit mapping). Stage 1 registers the sample; stage 2
// inverts the observed response, compares it with the applied code and
// updates coverage, error count and first-error capture.
module rftfa_checker #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             sample_valid,
    input  logic [3:0]       applied,
    input  logic [3:0]       observed,
    output logic [3:0]       recovered,
    output logic             mismatch,
    output logic [CNT_W-1:0] err_count,
    output logic [15:0]      seen,
    output logic             done,
    output logic             first_err_valid,
    output logic [3:0]       first_err_code
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COLLECT  = 2'd1,
        COMPLETE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic             r_s1_valid;
    logic [3:0]       r_s1_applied;
    logic [3:0]       r_s1_observed;

    logic [3:0]       r_recovered;
    logic             r_mismatch;
    logic [CNT_W-1:0] r_err_count;
    logic [15:0]      r_seen;
    logic             r_first_err_valid;
    logic [3:0]       r_first_err_code;

    logic             w_a;
    logic             w_b;
    logic             w_c;
    logic             w_d;
    logic [3:0]       w_inv;
    logic             w_mismatch;
    logic [15:0]      w_seen_next;

    // Inverse mapping of the stage-1 response plus compare and coverage update.
    always_comb begin
        w_a         = r_s1_observed[3];
        w_b         = r_s1_observed[3] ^ r_s1_observed[2];
        w_c         = r_s1_observed[2] ^ r_s1_observed[1];
        w_d         = r_s1_observed[0] ^ ((w_a ^ w_b) & w_c) ^ (w_a & w_b);
        w_inv       = {w_a, w_b, w_c, w_d};
        w_mismatch  = r_s1_valid && (w_inv != r_s1_applied);
        w_seen_next = r_seen;
        if (r_s1_valid) begin
            w_seen_next = r_seen | (16'h0001 << r_s1_applied);
        end
    end

    // Stage 1: capture the incoming sample; clear discards it and any in-flight one.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_s1_valid    <= 1'b0;
            r_s1_applied  <= '0;
            r_s1_observed <= '0;
        end else begin
            r_s1_valid    <= sample_valid;
            r_s1_applied  <= applied;
            r_s1_observed <= observed;
        end
    end

    // Stage 2: result registers, saturating error count and first-error capture.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_recovered       <= '0;
            r_mismatch        <= 1'b0;
            r_err_count       <= '0;
            r_seen            <= '0;
            r_first_err_valid <= 1'b0;
            r_first_err_code  <= '0;
        end else begin
            r_mismatch <= w_mismatch;
            r_seen     <= w_seen_next;
            if (r_s1_valid) begin
                r_recovered <= w_inv;
            end
            if (w_mismatch && (r_err_count != '1)) begin
                r_err_count <= r_err_count + CNT_W'(1);
            end
            if (w_mismatch && !r_first_err_valid) begin
                r_first_err_valid <= 1'b1;
                r_first_err_code  <= r_s1_applied;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state: COMPLETE is entered on the edge that fills the bitmap.
    always_comb begin
        w_state_next = r_state;
        if (clear) begin
            w_state_next = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (r_s1_valid) begin
                        w_state_next = (w_seen_next == '1) ? COMPLETE : COLLECT;
                    end
                end
                COLLECT: begin
                    if (w_seen_next == '1) begin
                        w_state_next = COMPLETE;
                    end
                end
                COMPLETE: begin
                    w_state_next = COMPLETE;
                end
                default: begin
                    w_state_next = IDLE;
                end
            endcase
        end
    end

    assign recovered       = r_recovered;
    assign mismatch        = r_mismatch;
    assign err_count       = r_err_count;
    assign seen            = r_seen;
    assign done            = (r_state == COMPLETE);
    assign first_err_valid = r_first_err_valid;
    assign first_err_code  = r_first_err_code;

endmodule
